// File: rtl/ps2_key_encoder_pkg.sv
// Shared constants for the PS/2 key encoder: game key codes, scan-code set 2 bytes,
// frame/decoder state encodings and the scan-code to game-code map.
package ps2_key_encoder_pkg;

  // Game key codes driven onto Game.key
  localparam logic [7:0] KEY_NONE  = 8'h00;
  localparam logic [7:0] KEY_LEFT  = 8'h80;
  localparam logic [7:0] KEY_RIGHT = 8'h79;
  localparam logic [7:0] KEY_DOWN  = 8'h81;
  localparam logic [7:0] KEY_ROT_R = 8'h82;
  localparam logic [7:0] KEY_ROT_L = 8'h29;
  localparam logic [7:0] KEY_START = 8'h40;

  // Set-2 prefixes and scan codes
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_RIGHT  = 8'h74;
  localparam logic [7:0] SC_DOWN   = 8'h72;
  localparam logic [7:0] SC_UP     = 8'h75;
  localparam logic [7:0] SC_Z      = 8'h1A;
  localparam logic [7:0] SC_ENTER  = 8'h5A;

  // Keyboard status/response bytes that never form part of a key sequence
  localparam logic [7:0] SC_BAT_OK = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_ECHO   = 8'hEE;
  localparam logic [7:0] SC_ERR0   = 8'h00;
  localparam logic [7:0] SC_ERR1   = 8'hFF;

  typedef logic [1:0] frame_state_t;
  typedef logic [1:0] dec_state_t;

  localparam frame_state_t F_IDLE   = 2'd0;
  localparam frame_state_t F_DATA   = 2'd1;
  localparam frame_state_t F_PARITY = 2'd2;
  localparam frame_state_t F_STOP   = 2'd3;

  localparam dec_state_t DEC_IDLE    = 2'd0;
  localparam dec_state_t DEC_EXT     = 2'd1;
  localparam dec_state_t DEC_BRK     = 2'd2;
  localparam dec_state_t DEC_EXT_BRK = 2'd3;

  function automatic logic [7:0] map_key(input logic ext, input logic [7:0] code);
    logic [7:0] m;
    m = KEY_NONE;
    case ({ext, code})
      {1'b1, SC_LEFT}:  m = KEY_LEFT;
      {1'b1, SC_RIGHT}: m = KEY_RIGHT;
      {1'b1, SC_DOWN}:  m = KEY_DOWN;
      {1'b1, SC_UP}:    m = KEY_ROT_R;
      {1'b0, SC_Z}:     m = KEY_ROT_L;
      {1'b0, SC_ENTER}: m = KEY_START;
      default:          m = KEY_NONE;
    endcase
    return m;
  endfunction

  function automatic logic is_ctrl_byte(input logic [7:0] code);
    return (code == SC_BAT_OK) || (code == SC_ACK) || (code == SC_RESEND) ||
           (code == SC_ECHO) || (code == SC_ERR0) || (code == SC_ERR1);
  endfunction

endpackage

// File: rtl/ps2_key_encoder_frame_rx.sv
// PS/2 frame receiver: pin synchronizer, falling-edge detect, 11-bit frame FSM and
// inactivity timeout. Odd-parity checking is compiled in with PS2_PARITY_CHECK_EN.
module ps2_key_encoder_frame_rx
  import ps2_key_encoder_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] TmoMax = CntW'(TIMEOUT_CYC - 1);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic                   r_clk_prev;
  frame_state_t           r_state;
  logic [7:0]             r_shift;
  logic [2:0]             r_bit_cnt;
  logic                   r_parity;
  logic [CntW-1:0]        r_tmo_cnt;

  logic                   w_clk_s;
  logic                   w_data_s;
  logic                   w_fall;
  logic                   w_par_err;
  frame_state_t           w_state_nxt;
  logic [7:0]             w_shift_nxt;
  logic [2:0]             w_bit_cnt_nxt;
  logic                   w_parity_nxt;
  logic [CntW-1:0]        w_tmo_cnt_nxt;

  assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
  assign w_data_s = r_data_sync[SYNC_STAGES-1];
  assign w_fall   = r_clk_prev & ~w_clk_s;

`ifdef PS2_PARITY_CHECK_EN
  // Keyboard sends odd parity over data+parity; an even count means corruption
  assign w_par_err = ~(^{r_shift, r_parity});
`else
  assign w_par_err = r_parity & 1'b0;
`endif

  // Idle-high pins, so the synchronizer resets to 1 to avoid a false edge
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
      r_clk_prev  <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], i_ps2_data};
      r_clk_prev  <= w_clk_s;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_parity_nxt  = r_parity;
    w_tmo_cnt_nxt = r_tmo_cnt;
    o_byte_valid  = 1'b0;
    o_frame_err   = 1'b0;
    if (w_fall) begin
      w_tmo_cnt_nxt = '0;
      unique case (r_state)
        F_IDLE: begin
          if (!w_data_s) begin
            w_state_nxt   = F_DATA;
            w_bit_cnt_nxt = 3'd0;
          end
        end
        F_DATA: begin
          w_shift_nxt   = {w_data_s, r_shift[7:1]};
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) w_state_nxt = F_PARITY;
        end
        F_PARITY: begin
          w_parity_nxt = w_data_s;
          w_state_nxt  = F_STOP;
        end
        F_STOP: begin
          if (w_data_s && !w_par_err) o_byte_valid = 1'b1;
          else                        o_frame_err  = 1'b1;
          w_state_nxt = F_IDLE;
        end
        default: w_state_nxt = F_IDLE;
      endcase
    end else if (r_state != F_IDLE) begin
      if (r_tmo_cnt == TmoMax) begin
        w_state_nxt   = F_IDLE;
        w_tmo_cnt_nxt = '0;
        o_frame_err   = 1'b1;
      end else begin
        w_tmo_cnt_nxt = r_tmo_cnt + CntW'(1);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= F_IDLE;
      r_shift   <= 8'h00;
      r_bit_cnt <= 3'd0;
      r_parity  <= 1'b0;
      r_tmo_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_parity  <= w_parity_nxt;
      r_tmo_cnt <= w_tmo_cnt_nxt;
    end
  end

  assign o_byte = r_shift;

endmodule

// File: rtl/ps2_key_encoder.sv
// PS/2 keyboard to game key encoder: decodes E0/F0 prefixed set-2 sequences into a held
// game key code. Optional odd-parity check enabled by defining PS2_PARITY_CHECK_EN.
module ps2_key_encoder
  import ps2_key_encoder_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key,
  output logic       key_event,
  output logic       frame_err
);

  logic [7:0] w_byte;
  logic       w_byte_valid;
  logic       w_frame_err;

  dec_state_t r_dec;
  logic [7:0] r_key;
  logic       r_key_event;
  logic       r_frame_err;

  dec_state_t w_dec_nxt;
  logic [7:0] w_key_nxt;
  logic       w_event;
  logic       w_ext;
  logic [7:0] w_mapped;

  ps2_key_encoder_frame_rx #(
    .SYNC_STAGES(SYNC_STAGES),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_frame_rx (
    .Clk         (Clk),
    .Reset       (Reset),
    .i_ps2_clk   (ps2_clk),
    .i_ps2_data  (ps2_data),
    .o_byte      (w_byte),
    .o_byte_valid(w_byte_valid),
    .o_frame_err (w_frame_err)
  );

  assign w_ext    = (r_dec == DEC_EXT) || (r_dec == DEC_EXT_BRK);
  assign w_mapped = map_key(w_ext, w_byte);

  always_comb begin
    w_dec_nxt = r_dec;
    w_key_nxt = r_key;
    w_event   = 1'b0;
    if (w_byte_valid) begin
      if (is_ctrl_byte(w_byte)) begin
        w_dec_nxt = DEC_IDLE;
      end else begin
        unique case (r_dec)
          DEC_IDLE, DEC_EXT: begin
            if (w_byte == PS2_BRK) begin
              w_dec_nxt = (r_dec == DEC_EXT) ? DEC_EXT_BRK : DEC_BRK;
            end else if (w_byte == PS2_EXT && r_dec == DEC_IDLE) begin
              w_dec_nxt = DEC_EXT;
            end else begin
              // Make: typematic repeats of the held key leave key_event quiet
              w_dec_nxt = DEC_IDLE;
              if (w_mapped != KEY_NONE && w_mapped != r_key) begin
                w_key_nxt = w_mapped;
                w_event   = 1'b1;
              end
            end
          end
          DEC_BRK, DEC_EXT_BRK: begin
            w_dec_nxt = DEC_IDLE;
            if (w_mapped != KEY_NONE && w_mapped == r_key) begin
              w_key_nxt = KEY_NONE;
              w_event   = 1'b1;
            end
          end
          default: w_dec_nxt = DEC_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_dec       <= DEC_IDLE;
      r_key       <= KEY_NONE;
      r_key_event <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_dec       <= w_dec_nxt;
      r_key       <= w_key_nxt;
      r_key_event <= w_event;
      r_frame_err <= w_frame_err;
    end
  end

  assign key       = r_key;
  assign key_event = r_key_event;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Directed and randomized bench for ps2_key_encoder against a sequence-level reference model.
module tb_ps2_key_encoder;

  localparam int unsigned SYNC = 2;
  localparam int unsigned TMO  = 300;
  localparam int          HALF = 8;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] key;
  logic       key_event;
  logic       frame_err;

  int checks = 0;
  int failures = 0;
  int ev_cnt = 0;
  int err_cnt = 0;
  int exp_ev = 0;
  int exp_err = 0;
  logic [7:0] exp_key = 8'h00;
  logic [7:0] pend[$];

  ps2_key_encoder #(
    .SYNC_STAGES(SYNC),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .key      (key),
    .key_event(key_event),
    .frame_err(frame_err)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (key_event) ev_cnt <= ev_cnt + 1;
    if (frame_err) err_cnt <= err_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Game-code table: scan code, extended flag, game code
  function automatic logic [7:0] ref_map(input logic ext, input logic [7:0] code);
    logic [7:0] sc[6];
    logic       ex[6];
    logic [7:0] gc[6];
    sc = '{8'h6B, 8'h74, 8'h72, 8'h75, 8'h1A, 8'h5A};
    ex = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    gc = '{8'h80, 8'h79, 8'h81, 8'h82, 8'h29, 8'h40};
    for (int i = 0; i < 6; i++) if (sc[i] == code && ex[i] == ext) return gc[i];
    return 8'h00;
  endfunction

  // Reference: collect bytes until a complete make/break sequence, then apply it
  task automatic model_byte(input logic [7:0] b);
    logic ext, brk;
    logic [7:0] m;
    if (b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF}) begin
      pend.delete();
      return;
    end
    pend.push_back(b);
    if (pend.size() == 1 && (b == 8'hE0 || b == 8'hF0)) return;
    if (pend.size() == 2 && pend[0] == 8'hE0 && pend[1] == 8'hF0) return;
    ext = (pend[0] == 8'hE0);
    brk = (pend.size() >= 2) && (pend[pend.size()-2] == 8'hF0);
    m = ref_map(ext, b);
    pend.delete();
    if (m != 8'h00) begin
      if (!brk && m != exp_key) begin
        exp_key = m;
        exp_ev++;
      end else if (brk && m == exp_key) begin
        exp_key = 8'h00;
        exp_ev++;
      end
    end
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] b, input logic stop,
                                             input logic flip);
    return {stop, (~^b) ^ flip, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      cyc(HALF);
      ps2_clk = 1'b0;
      cyc(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(frame_bits(b, 1'b1, 1'b0), 11);
    model_byte(b);
    cyc(20);
  endtask

  logic [7:0] pool[10] = '{8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h72, 8'h75, 8'h1A, 8'h5A, 8'hAA, 8'h33};

  initial begin
    int ev0, err0;
    logic [7:0] b;
    logic       bad;

    cyc(3);
    chk("reset_key", key, 8'h00);
    chk("reset_event", key_event, 1'b0);
    chk("reset_err", frame_err, 1'b0);
    Reset = 1'b0;
    cyc(5);

    // 1: E0 6B with exact latency, then E0 F0 6B
    ev0 = ev_cnt;
    send_byte(8'hE0);
    send_bits(frame_bits(8'h6B, 1'b1, 1'b0), 10);
    ps2_data = 1'b1;
    cyc(HALF);
    ps2_clk = 1'b0;
    cyc(SYNC);
    chk("t1_before_n1", key, 8'h00);
    cyc(1);
    chk("t1_at_n1", key, 8'h80);
    chk("t1_event_n1", key_event, 1'b1);
    cyc(1);
    chk("t1_event_gone", key_event, 1'b0);
    cyc(HALF - SYNC - 2);
    ps2_clk = 1'b1;
    model_byte(8'h6B);
    cyc(20);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h6B);
    chk("t1_release", key, 8'h00);
    chk("t1_events", ev_cnt - ev0, 2);

    // 2: overlapping keys, foreign break ignored
    send_byte(8'h1A);
    chk("t2_rotl", key, 8'h29);
    send_byte(8'hE0);
    send_byte(8'h74);
    chk("t2_right", key, 8'h79);
    send_byte(8'hF0);
    send_byte(8'h1A);
    chk("t2_foreign_brk", key, 8'h79);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h74);
    chk("t2_release", key, 8'h00);

    // 3: typematic repeats
    ev0 = ev_cnt;
    for (int i = 0; i < 5; i++) send_byte(8'h5A);
    chk("t3_start", key, 8'h40);
    chk("t3_one_event", ev_cnt - ev0, 1);
    send_byte(8'hF0);
    send_byte(8'h5A);
    chk("t3_release", key, 8'h00);

    // 4: partial frame timeout
    err0 = err_cnt;
    send_bits(frame_bits(8'h1A, 1'b1, 1'b0), 5);
    cyc(TMO + 20);
    exp_err++;
    chk("t4_timeout_err", err_cnt - err0, 1);
    send_byte(8'h1A);
    chk("t4_after", key, 8'h29);

    // 5: bad stop, then bad parity
    send_byte(8'hF0);
    send_byte(8'h1A);
    err0 = err_cnt;
    send_bits(frame_bits(8'h1A, 1'b0, 1'b0), 11);
    cyc(20);
    exp_err++;
    chk("t5_stop_err", err_cnt - err0, 1);
    chk("t5_stop_key", key, 8'h00);
    err0 = err_cnt;
    send_bits(frame_bits(8'h1A, 1'b1, 1'b1), 11);
    cyc(20);
`ifdef PS2_PARITY_CHECK_EN
    exp_err++;
    chk("t5_par_err", err_cnt - err0, 1);
`else
    model_byte(8'h1A);
    chk("t5_par_err", err_cnt - err0, 0);
`endif
    chk("t5_par_key", key, exp_key);

    // 6: reset mid-frame
    send_byte(8'hE0);
    send_byte(8'h72);
    chk("t6_down", key, 8'h81);
    ev0 = ev_cnt;
    err0 = err_cnt;
    send_bits(frame_bits(8'h5A, 1'b1, 1'b0), 4);
    Reset = 1'b1;
    cyc(1);
    chk("t6_reset_key", key, 8'h00);
    cyc(3);
    Reset = 1'b0;
    exp_key = 8'h00;
    pend.delete();
    cyc(TMO + 20);
    chk("t6_no_events", ev_cnt - ev0, 0);
    chk("t6_no_err", err_cnt - err0, 0);
    send_byte(8'hE0);
    send_byte(8'h72);
    chk("t6_down_again", key, 8'h81);

    // Random byte streams with occasional corrupted stop bits
    for (int i = 0; i < 60; i++) begin
      b = (i % 7 == 6) ? 8'($urandom_range(0, 255)) : pool[$urandom_range(0, 9)];
      bad = ($urandom_range(0, 9) == 0);
      if (bad) begin
        send_bits(frame_bits(b, 1'b0, 1'b0), 11);
        exp_err++;
        cyc(20);
      end else begin
        send_byte(b);
      end
      chk($sformatf("rand_key_%0d", i), key, exp_key);
    end

    cyc(10);
    chk("total_events", ev_cnt, exp_ev);
    chk("total_errs", err_cnt, exp_err);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
